ddr3_wr_burst_ctrl: RTL and testbench

Sequencer that drains the 256-bit read side of the write-path width-converting FIFO into the DDR3 controller's AXI4-style write channels. It waits until a full burst of data is buffered, then issues one address phase and streams BURST_LEN beats. It then waits for the write response and advances the DDR3 write pointer inside a configurable ring region. It sits between the write FIFO and the DDR3 controller user port.

---
 rtl/ddr3_wr_pkg.sv | 20 ++
 rtl/ddr3_wr_burst_ctrl_if.sv | 27 ++
 rtl/ddr3_wr_skid.sv | 43 ++++
 rtl/ddr3_wr_burst_ctrl.sv | 151 +++++++++++++++
 tb/tb_ddr3_wr_burst_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_wr_pkg.sv
// rtl/ddr3_wr_pkg.sv - shared state encoding, beat size and AXI response codes for the DDR3 write sequencer
package ddr3_wr_pkg;

  localparam int BYTES_PER_BEAT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/ddr3_wr_burst_ctrl_if.sv
// rtl/ddr3_wr_burst_ctrl_if.sv - AXI4-style AW/W/B channel bundle between the sequencer and the DDR3 user port
interface ddr3_wr_burst_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wlast;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ddr3_wr_skid.sv
// rtl/ddr3_wr_skid.sv - two-entry skid buffer holding FIFO read returns until the W channel accepts them
module ddr3_wr_skid #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occupancy,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem [2];
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign occupancy = cnt;
  assign head      = mem[rp];
endmodule

// File: rtl/ddr3_wr_burst_ctrl.sv
// rtl/ddr3_wr_burst_ctrl.sv - drains the write FIFO into DDR3 AXI write bursts inside a ring region
// Optional DDR3_WR_STAT_EN adds burst_cnt and sticky resp_err outputs.
module ddr3_wr_burst_ctrl #(
  parameter int DATA_W         = 256,
  parameter int LVL_W          = 7,
  parameter int ADDR_W         = 28,
  parameter int BURST_LEN      = 16,
  parameter int BYTES_PER_BEAT = ddr3_wr_pkg::BYTES_PER_BEAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    region_bytes,
  input  logic [DATA_W-1:0]    fifo_rd_data,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_empty,
  input  logic [LVL_W-1:0]     fifo_rd_level,
  ddr3_wr_burst_ctrl_if.master axi,
  output logic                 busy,
  output logic [ADDR_W-1:0]    wr_ptr
`ifdef DDR3_WR_STAT_EN
  ,
  output logic [31:0]          burst_cnt,
  output logic                 resp_err
`endif
);
  import ddr3_wr_pkg::*;

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int BURST_BYTES = BURST_LEN * BYTES_PER_BEAT;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ADDR = ADDR;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state;
  logic              ptr_init;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] region_q;
  logic [CNT_W-1:0]  reads_issued;
  logic [CNT_W-1:0]  beat_cnt;
  logic              rd_inflight;
  logic [1:0]        skid_occ;
  logic [DATA_W-1:0] skid_head;
  logic              beat_pop;
  logic              last_beat;
  logic [2:0]        skid_load;
  logic [ADDR_W:0]   ptr_next;
  logic [ADDR_W:0]   ring_end;

  // A beat leaving this cycle frees its slot, which keeps reads streaming back-to-back.
  assign skid_load  = {1'b0, skid_occ} + {2'b00, rd_inflight} - {2'b00, beat_pop};
  assign fifo_rd_en = ((state == ST_ADDR) || (state == ST_DATA)) &&
                      (reads_issued < CNT_W'(BURST_LEN)) &&
                      !fifo_rd_empty && (skid_load < 3'd2);

  assign axi.awvalid = (state == ST_ADDR);
  assign axi.awaddr  = (state == ST_ADDR) ? wr_ptr : '0;
  assign axi.awlen   = 8'(BURST_LEN - 1);
  assign axi.wvalid  = (state == ST_DATA) && (skid_occ != 2'd0);
  assign axi.wdata   = skid_head;
  assign last_beat   = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign axi.wlast   = axi.wvalid && last_beat;
  assign axi.bready  = (state == ST_RESP);
  assign beat_pop    = axi.wvalid && axi.wready;
  assign busy        = (state != ST_IDLE);

  assign ptr_next = {1'b0, wr_ptr} + (ADDR_W + 1)'(BURST_BYTES);
  assign ring_end = {1'b0, base_q} + {1'b0, region_q};

  ddr3_wr_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (fifo_rd_data),
    .pop       (beat_pop),
    .occupancy (skid_occ),
    .head      (skid_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr_init     <= 1'b0;
      wr_ptr       <= '0;
      base_q       <= '0;
      region_q     <= '0;
      reads_issued <= '0;
      beat_cnt     <= '0;
      rd_inflight  <= 1'b0;
    end else begin
      rd_inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        reads_issued <= reads_issued + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          base_q       <= base_addr;
          region_q     <= region_bytes;
          reads_issued <= '0;
          beat_cnt     <= '0;
          if (!ptr_init) begin
            wr_ptr   <= base_addr;
            ptr_init <= 1'b1;
          end
          if (enable && (fifo_rd_level >= LVL_W'(BURST_LEN))) begin
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi.awready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_pop) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (last_beat) begin
              state <= ST_RESP;
            end
          end
        end
        default: begin
          // Error responses still retire the burst; there is no retry path.
          if (axi.bvalid) begin
            wr_ptr <= (ptr_next >= ring_end) ? base_q : ptr_next[ADDR_W-1:0];
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DDR3_WR_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
      resp_err  <= 1'b0;
    end else if (axi.bvalid && axi.bready) begin
      burst_cnt <= burst_cnt + 32'd1;
      if (axi.bresp != OKAY) begin
        resp_err <= 1'b1;
      end
    end
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^axi.bresp;
`endif
endmodule

// File: tb/tb_ddr3_wr_burst_ctrl.sv
// tb/tb_ddr3_wr_burst_ctrl.sv - table-driven scoreboard bench for ddr3_wr_burst_ctrl
module tb_ddr3_wr_burst_ctrl;
  import ddr3_wr_pkg::*;

  localparam int NV = 11;

  typedef struct {
    bit          do_reset;
    logic [27:0] base;
    logic [27:0] region;
    int          n_load;
    int          aw_delay;
    bit          w_toggle;
    bit          drop_en;
    logic [1:0]  bresp;
    logic [27:0] exp_awaddr;
    logic [27:0] exp_wr_ptr;
    int          exp_bcnt;
    bit          exp_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [27:0]  base_addr;
  logic [27:0]  region_bytes;
  logic [255:0] fifo_rd_data;
  logic         fifo_rd_en;
  logic         fifo_rd_empty;
  logic [6:0]   fifo_rd_level;
  logic         busy;
  logic [27:0]  wr_ptr;
`ifdef DDR3_WR_STAT_EN
  logic [31:0]  burst_cnt;
  logic         resp_err;
`endif

  ddr3_wr_burst_ctrl_if #(.ADDR_W(28), .DATA_W(256)) bus ();

  ddr3_wr_burst_ctrl #(
    .DATA_W(256), .LVL_W(7), .ADDR_W(28), .BURST_LEN(16), .BYTES_PER_BEAT(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .base_addr     (base_addr),
    .region_bytes  (region_bytes),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_level (fifo_rd_level),
    .axi           (bus),
    .busy          (busy),
    .wr_ptr        (wr_ptr)
`ifdef DDR3_WR_STAT_EN
    ,
    .burst_cnt     (burst_cnt),
    .resp_err      (resp_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int level = 0;
  int load_idx = 0;
  int rd_idx = 0;
  int rd_pulses, aw_seen, aw_hs, b_hs, beat, first_beat_cyc, last_beat_cyc;
  logic [27:0]  exp_aw [$];
  logic [255:0] exp_w [$];
  vec_t vecs [NV];

  assign fifo_rd_level = 7'(level);
  assign fifo_rd_empty = (level == 0);

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name, string got, string want);
    checks++;
    errors++;
    $display("FAIL %s: got %s, expected %s", name, got, want);
  endfunction

  function automatic logic [255:0] word(int n);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'h5A00_0000 ^ 32'(n * 8 + i);
    return w;
  endfunction

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      exp_w.push_back(word(load_idx));
      load_idx++;
      level++;
    end
  endtask

  // One clock: observe mid-cycle, score handshakes, then model the FIFO read return.
  task automatic cycle();
    bit rd;
    logic [255:0] e;
    #4;
    rd = fifo_rd_en;
    if (rd) rd_pulses++;
    if (bus.awvalid) begin
      aw_seen++;
      if (exp_aw.size() != 0) chk("awaddr", bus.awaddr, exp_aw[0]);
      else fail("aw_unexpected", "address phase", "none");
      chk("awlen", bus.awlen, 15);
      if (bus.awready) begin
        aw_hs++;
        if (exp_aw.size() != 0) void'(exp_aw.pop_front());
      end
    end
    if (bus.wvalid && bus.wready) begin
      if (exp_w.size() != 0) begin
        e = exp_w.pop_front();
        chk("wdata", bus.wdata, e);
      end else begin
        fail("w_unexpected", "extra beat", "no beat");
      end
      chk("wlast", bus.wlast, (beat == 15));
      if (beat == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beat++;
    end
    if (bus.bvalid && bus.bready) b_hs++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      fifo_rd_data = word(rd_idx);
      rd_idx++;
      level--;
    end
  endtask

  task automatic apply_reset(input logic [27:0] b, input logic [27:0] r);
    base_addr = b;
    region_bytes = r;
    enable = 1'b0;
    rst = 1'b1;
    level = 0;
    rd_idx = load_idx;
    exp_aw.delete();
    exp_w.delete();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    chk("rst_wr_ptr", wr_ptr, b);
  endtask

  task automatic run_burst(input vec_t v);
    int first_aw;
    int aw0;
    if (v.do_reset) apply_reset(v.base, v.region);
    base_addr = v.base;
    region_bytes = v.region;
    exp_aw.push_back(v.exp_awaddr);
    load(v.n_load);
    aw_seen = 0; aw_hs = 0; b_hs = 0; beat = 0; rd_pulses = 0; first_aw = -1;
    first_beat_cyc = 0; last_beat_cyc = 0;
    enable = 1'b1;
    for (int k = 0; k < 400 && b_hs == 0; k++) begin
      bus.awready = (aw_seen >= v.aw_delay);
      bus.wready = v.w_toggle ? (cyc % 2 == 0) : 1'b1;
      bus.bvalid = 1'b1;
      bus.bresp = v.bresp;
      if (v.drop_en && aw_hs != 0) enable = 1'b0;
      cycle();
      if (first_aw < 0 && aw_seen != 0) first_aw = k;
    end
    if (b_hs == 0) fail("burst_timeout", "no response handshake", "one");
    chk("wr_ptr", wr_ptr, v.exp_wr_ptr);
    chk("beats", beat, 16);
    chk("rd_pulses", rd_pulses, 16);
    chk("aw_handshakes", aw_hs, 1);
    chk("aw_latency_le2", (first_aw >= 0 && first_aw <= 2), 1);
    chk("busy_after", busy, 0);
    if (!v.w_toggle) chk("b2b_span", last_beat_cyc - first_beat_cyc, 15);
`ifdef DDR3_WR_STAT_EN
    chk("burst_cnt", burst_cnt, v.exp_bcnt);
    chk("resp_err", resp_err, v.exp_err);
`endif
    if (v.drop_en) begin
      aw0 = aw_seen;
      repeat (20) cycle();
      chk("hold_after_drop", aw_seen, aw0);
      chk("idle_after_drop", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int viol;
    //            rst  base         region      load dly tog drop bresp   awaddr       wr_ptr      cnt err
    vecs[0]  = '{1'b1, 28'h0000000, 28'h0004000, 16, 0, 1'b0, 1'b0, OKAY,   28'h0000000, 28'h0000200, 1, 1'b0};
    vecs[1]  = '{1'b0, 28'h0000000, 28'h0004000, 16, 5, 1'b1, 1'b0, OKAY,   28'h0000200, 28'h0000400, 2, 1'b0};
    vecs[2]  = '{1'b1, 28'h0000000, 28'h0000400, 16, 0, 1'b0, 1'b0, OKAY,   28'h0000000, 28'h0000200, 1, 1'b0};
    vecs[3]  = '{1'b0, 28'h0000000, 28'h0000400, 16, 1, 1'b0, 1'b0, OKAY,   28'h0000200, 28'h0000000, 2, 1'b0};
    vecs[4]  = '{1'b1, 28'h0001000, 28'h0000600, 16, 2, 1'b1, 1'b0, OKAY,   28'h0001000, 28'h0001200, 1, 1'b0};
    vecs[5]  = '{1'b0, 28'h0001000, 28'h0000600, 16, 0, 1'b0, 1'b0, SLVERR, 28'h0001200, 28'h0001400, 2, 1'b1};
    vecs[6]  = '{1'b0, 28'h0001000, 28'h0000600, 32, 0, 1'b0, 1'b1, OKAY,   28'h0001400, 28'h0001000, 3, 1'b1};
    vecs[7]  = '{1'b0, 28'h0001000, 28'h0000600,  0, 3, 1'b1, 1'b0, OKAY,   28'h0001000, 28'h0001200, 4, 1'b1};
    vecs[8]  = '{1'b1, 28'hFFFFC00, 28'h0000400, 16, 0, 1'b0, 1'b0, OKAY,   28'hFFFFC00, 28'hFFFFE00, 1, 1'b0};
    vecs[9]  = '{1'b0, 28'hFFFFC00, 28'h0000400, 16, 0, 1'b1, 1'b0, OKAY,   28'hFFFFE00, 28'hFFFFC00, 2, 1'b0};
    vecs[10] = '{1'b0, 28'hFFFFC00, 28'h0000400,  1, 0, 1'b0, 1'b0, OKAY,   28'hFFFFC00, 28'hFFFFE00, 3, 1'b0};

    rst = 1'b1;
    enable = 1'b0;
    base_addr = 28'h0000100;
    region_bytes = 28'h0004000;
    fifo_rd_data = '0;
    bus.awready = 1'b1;
    bus.wready = 1'b1;
    bus.bvalid = 1'b0;
    bus.bresp = OKAY;
    level = 64;
    #100;
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_wlast", bus.wlast, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_wr_ptr_zero", wr_ptr, 0);
`ifdef DDR3_WR_STAT_EN
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_resp_err", resp_err, 0);
`endif
    #100;
    rst = 1'b0;
    @(posedge clk);
    #1;
    viol = 0;
    rd_pulses = 0;
    aw_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || bus.wvalid || bus.bready) viol++;
      cycle();
    end
    chk("idle_activity", viol, 0);
    chk("idle_rd_pulses", rd_pulses, 0);
    chk("idle_aw", aw_seen, 0);
    chk("idle_wr_ptr", wr_ptr, 28'h0000100);
    level = 0;

    for (int i = 0; i < NV; i++) begin
      if (i == 10) begin
        load(15);
        enable = 1'b1;
        aw_seen = 0;
        rd_pulses = 0;
        for (int k = 0; k < 20; k++) cycle();
        chk("thr_no_aw", aw_seen, 0);
        chk("thr_no_rd", rd_pulses, 0);
        chk("thr_idle", busy, 0);
      end
      run_burst(vecs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
